risc_datapath_param: RTL
========================

// Module: risc_datapath_param
// PURPOSE
//  Parametrised successor of the 16-bit RISC datapath: NREG x W register file (2 read, 1 write),
//  4-source write-back mux, 8-op ALU with registered result and registered status flags.
//  Sits between the control-unit FSM (drives all selects/enables) and data memory (R_data in,
//  Rp/Rq data out). Adds configurable width/depth, R0-hardwired-zero mode and write-to-read bypass.
// PARAMETERS
//  W        16  datapath width (>=8)
//  NREG     16  number of registers (power of two, >=2)
//  AW       $clog2(NREG)  register address width (derived, do not override)
//  IMM_W    8   immediate width (< W)
//  BYPASS   1   1: read port returns same-cycle write data on address match; 0: returns old value
//  R0_ZERO  0   1: register 0 reads 0, writes to it ignored
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active high
//  R_data     in   W      data-memory read data (write-back source)
//  RF_W_data  in   IMM_W  immediate (write-back source)
//  RF_s       in   2      write-back select: 00 alu_out, 01 R_data, 10 imm zero-ext, 11 imm sign-ext
//  RF_W_addr  in   AW     write address
//  W_wr       in   1      write enable
//  RF_Rp_addr in   AW     read port P address
//  Rp_rd      in   1      read port P enable
//  RF_Rq_addr in   AW     read port Q address
//  Rq_rd      in   1      read port Q enable
//  alu_s      in   3      ALU op
//  alu_en     in   1      capture ALU result + flags this cycle
//  Rp_data_wire out W     port P data (0 when Rp_rd=0)
//  Rq_data_wire out W     port Q data (0 when Rq_rd=0)
//  RF_Rp_zero out  1      1 when Rp_data_wire==0 (combinational)
//  alu_out_wire out W     registered ALU result
//  flags      out  4      registered {N,V,C,Z}
// BEHAVIOUR
//  - Reset (async, rst=1): all registers, alu_out_wire, flags -> 0. Reads during reset return 0.
//  - Reads combinational. Disabled port drives 0 (so RF_Rp_zero=1 when Rp_rd=0).
//  - Write: on rising clk when W_wr=1, reg[RF_W_addr] <= mux(RF_s). Zero-ext pads 0s; sign-ext
//    replicates RF_W_data[IMM_W-1].
//  - Write source 00 uses the CURRENT alu_out_wire (result of the last alu_en cycle); a write with
//    RF_s=00 in the same cycle as alu_en stores the old result, new result visible next cycle.
//  - BYPASS=1: read addr == RF_W_addr with W_wr=1 -> read port shows the write-mux value same cycle.
//    BYPASS=0: old register value until the edge. Both ports bypass independently.
//  - R0_ZERO=1: address 0 always reads 0 (bypass included); writes to 0 dropped.
//  - ALU operands A=Rp_data_wire, B=Rq_data_wire (post-enable, post-bypass). Latency 1: on edge with
//    alu_en=1, alu_out_wire and flags update; alu_en=0 holds both.
//  - Ops: 000 ADD, 001 SUB(A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL1 A, 111 SHR1 A (logical).
//  - Width: result truncated to W. C = carry-out (ADD), borrow (SUB: 1 when A<B unsigned), bit shifted
//    out (SHL1 = A[W-1], SHR1 = A[0]), 0 for logic ops. V = signed overflow (ADD/SUB only, else 0).
//    Z = result==0, N = result[W-1].
//  - Wrap-around: ADD 0xFFFF+1 -> 0, C=1, Z=1; SUB 0-1 -> 0xFFFF, C=1, N=1.
//  - Reset mid-operation: pending write and ALU capture abandoned; nothing written after rst falls
//    until the next enabled edge.
// STRUCTURE
//  - Shared package risc_pkg: ALU op localparams (ALU_ADD..ALU_SHR), write-select encodings
//    (WB_ALU, WB_MEM, WB_IMMZ, WB_IMMS), flag bit indices.
//  - One sub-module: risc_regfile (NREG x W, 2R1W, async reset, BYPASS/R0_ZERO params).
//    ALU, write mux and flag registers live in this module.
// TESTING
//  1 Reset: load regs, assert rst mid-cycle -> all reads 0, alu_out_wire=0, flags=0 immediately.
//  2 Imm write: RF_W_data=0x85, RF_s=11 to r5, RF_s=10 to r6 -> r5=0xFF85, r6=0x0085.
//  3 ALU: r5=0xFFFF, r6=0x0001, ADD alu_en -> next cycle alu_out=0x0000, flags Z=1,C=1;
//    SUB 0-1 -> 0xFFFF, N=1,C=1; ADD 0x7FFF+1 -> 0x8000, V=1,N=1.
//  4 Write-back timing: alu_en ADD and RF_s=00 write same cycle -> reg gets previous result; RF_s=00
//    write next cycle -> new result.
//  5 Bypass: write 0x1234 to r3 while reading r3 -> BYPASS=1 reads 0x1234 that cycle; BYPASS=0 reads
//    old value, 0x1234 after edge.
//  6 R0_ZERO=1 / enables: write 0xABCD to r0 -> reads 0; Rp_rd=0 -> Rp_data_wire=0, RF_Rp_zero=1;
//    run with W=32, NREG=8 and repeat 3.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings for the parametrised RISC datapath: ALU opcodes,
// write-back source selects and bit positions inside the flags word.
package risc_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_IMMZ = 2'b10;
    localparam logic [1:0] WB_IMMS = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/risc_regfile.sv
// NREG x W register file, two combinational read ports and one write port.
// Optional same-cycle write-to-read bypass and hardwired-zero register 0.
module risc_regfile
    import risc_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREG    = 16,
    parameter int AW      = $clog2(NREG),
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [AW-1:0] w_addr,
    input  logic [W-1:0]  w_data,
    input  logic          rp_en,
    input  logic [AW-1:0] rp_addr,
    input  logic          rq_en,
    input  logic [AW-1:0] rq_addr,
    output logic [W-1:0]  rp_data,
    output logic [W-1:0]  rq_data
);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];
    logic         w_ok;

    // Writes to register 0 are dropped when it is hardwired to zero
    assign w_ok = w_en && !(R0_ZERO && (w_addr == '0));

    // Next register contents: only the addressed entry changes
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (w_ok) begin
            regs_d[w_addr] = w_data;
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Port P read: gated by enable and reset, then zero-reg, then bypass
    always_comb begin
        rp_data = '0;
        if (rp_en && !rst) begin
            if (R0_ZERO && (rp_addr == '0)) begin
                rp_data = '0;
            end else if (BYPASS && w_ok && (rp_addr == w_addr)) begin
                rp_data = w_data;
            end else begin
                rp_data = regs_q[rp_addr];
            end
        end
    end

    // Port Q read: same priority as port P, bypassed independently
    always_comb begin
        rq_data = '0;
        if (rq_en && !rst) begin
            if (R0_ZERO && (rq_addr == '0)) begin
                rq_data = '0;
            end else if (BYPASS && w_ok && (rq_addr == w_addr)) begin
                rq_data = w_data;
            end else begin
                rq_data = regs_q[rq_addr];
            end
        end
    end

endmodule

// File: rtl/risc_datapath_param.sv
// Parametrised RISC datapath: register file, 4-source write-back mux and an
// 8-op ALU whose result and {N,V,C,Z} flags are registered on alu_en.
module risc_datapath_param
    import risc_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREG    = 16,
    parameter int AW      = $clog2(NREG),
    parameter int IMM_W   = 8,
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     R_data,
    input  logic [IMM_W-1:0] RF_W_data,
    input  logic [1:0]       RF_s,
    input  logic [AW-1:0]    RF_W_addr,
    input  logic             W_wr,
    input  logic [AW-1:0]    RF_Rp_addr,
    input  logic             Rp_rd,
    input  logic [AW-1:0]    RF_Rq_addr,
    input  logic             Rq_rd,
    input  logic [2:0]       alu_s,
    input  logic             alu_en,
    output logic [W-1:0]     Rp_data_wire,
    output logic [W-1:0]     Rq_data_wire,
    output logic             RF_Rp_zero,
    output logic [W-1:0]     alu_out_wire,
    output logic [3:0]       flags
);

    logic [W-1:0] wb_data;
    logic [W-1:0] alu_out_q, alu_out_d;
    logic [3:0]   flags_q, flags_d;
    logic [W-1:0] op_a, op_b;
    logic [W:0]   sum_ext, diff_ext;
    logic [W-1:0] alu_res;
    logic         alu_c, alu_v;

    // Write-back source; WB_ALU takes the already-registered result
    always_comb begin
        wb_data = alu_out_q;
        case (RF_s)
            WB_ALU:  wb_data = alu_out_q;
            WB_MEM:  wb_data = R_data;
            WB_IMMZ: wb_data = {{(W-IMM_W){1'b0}}, RF_W_data};
            WB_IMMS: wb_data = {{(W-IMM_W){RF_W_data[IMM_W-1]}}, RF_W_data};
            default: wb_data = alu_out_q;
        endcase
    end

    risc_regfile #(
        .W       (W),
        .NREG    (NREG),
        .AW      (AW),
        .BYPASS  (BYPASS),
        .R0_ZERO (R0_ZERO)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .w_en    (W_wr),
        .w_addr  (RF_W_addr),
        .w_data  (wb_data),
        .rp_en   (Rp_rd),
        .rp_addr (RF_Rp_addr),
        .rq_en   (Rq_rd),
        .rq_addr (RF_Rq_addr),
        .rp_data (Rp_data_wire),
        .rq_data (Rq_data_wire)
    );

    assign op_a       = Rp_data_wire;
    assign op_b       = Rq_data_wire;
    assign RF_Rp_zero = (Rp_data_wire == '0);

    // ALU result, carry/borrow and signed overflow
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (alu_s)
            ALU_ADD: begin
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_v   = (op_a[W-1] == op_b[W-1]) && (sum_ext[W-1] != op_a[W-1]);
            end
            ALU_SUB: begin
                alu_res = diff_ext[W-1:0];
                alu_c   = diff_ext[W];
                alu_v   = (op_a[W-1] != op_b[W-1]) && (diff_ext[W-1] != op_a[W-1]);
            end
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_NOT: alu_res = ~op_a;
            ALU_SHL: begin
                alu_res = {op_a[W-2:0], 1'b0};
                alu_c   = op_a[W-1];
            end
            ALU_SHR: begin
                alu_res = {1'b0, op_a[W-1:1]};
                alu_c   = op_a[0];
            end
            default: alu_res = '0;
        endcase
    end

    // Capture result and flags only on alu_en, otherwise hold
    always_comb begin
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        if (alu_en) begin
            alu_out_d       = alu_res;
            flags_d[FLAG_N] = alu_res[W-1];
            flags_d[FLAG_V] = alu_v;
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_Z] = (alu_res == '0);
        end
    end

    // ALU result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

    assign alu_out_wire = alu_out_q;
    assign flags        = flags_q;

endmodule
